// File: rtl/pipe_seq_pkg.sv
// pipe_seq_pkg: shared state encoding and constants for the pipeline sequencer
package pipe_seq_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2,
        MD_DONE  = 2'd3
    } state_t;
    localparam int MD_CYCLES_DEF = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: hazard inputs and register-control outputs between datapath and sequencer
interface pipe_sequencer_if #(parameter int CNT_W = 16);
    logic [4:0] id_rs, id_rt, ex_WN;
    logic id_uses_rt, ex_MR, ex_md;
    logic mem_Branch, mem_bne, mem_zero, mem_MR, mem_MW, dmem_ready;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic pc_sel_branch, dmem_req, md_done;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_rs, id_rt, ex_WN, id_uses_rt, ex_MR, ex_md,
               mem_Branch, mem_bne, mem_zero, mem_MR, mem_MW, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               pc_sel_branch, dmem_req, md_done, state, stall_cnt
    );
    modport slave (
        input  id_rs, id_rt, ex_WN, id_uses_rt, ex_MR, ex_md,
               mem_Branch, mem_bne, mem_zero, mem_MR, mem_MW, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               pc_sel_branch, dmem_req, md_done, state, stall_cnt
    );
endinterface

// File: rtl/pipe_sequencer_md_timer.sv
// md_timer: loadable down-counter timing a mult/div occupancy of EX
module md_timer
    import pipe_seq_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int W = $clog2(MD_CYCLES);
    logic [W-1:0] cnt;
    // load with remaining busy cycles, count down while busy, never wrap
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= W'(MD_CYCLES - 1);
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign last = cnt == W'(1);
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: stall/flush/enable control for the 5-stage pipeline
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic reset,
    pipe_sequencer_if.slave bus
);
    state_t st, nxt;
    logic [CNT_W-1:0] cnt;
    logic [4:0] we;
    logic [3:0] fl;
    logic memop, taken, lu, wait_mem, sel, mdd, md_load, md_last;
    assign memop    = bus.mem_MR | bus.mem_MW;
    assign taken    = bus.mem_Branch & (bus.mem_bne ? ~bus.mem_zero : bus.mem_zero);
    assign lu       = bus.ex_MR && bus.ex_WN != REG_ZERO &&
                      (bus.ex_WN == bus.id_rs || (bus.id_uses_rt && bus.ex_WN == bus.id_rt));
    assign wait_mem = memop & ~bus.dmem_ready;
    md_timer #(.MD_CYCLES(MD_CYCLES)) u_timer (
        .clk(clk), .reset(reset), .load(md_load), .dec(st == MD_BUSY), .last(md_last)
    );
    // we = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
    always_comb begin
        we = 5'b00000;
        fl = 4'b0000;
        sel = 1'b0;
        mdd = 1'b0;
        md_load = 1'b0;
        nxt = st;
        if (reset) begin
            nxt = RUN;
        end else if (wait_mem && st != MD_DONE) begin
            fl = 4'b0001;
            nxt = st == MD_BUSY ? (md_last ? MD_DONE : MD_BUSY) : MEM_WAIT;
        end else if (st == MD_BUSY) begin
            we = 5'b00011;
            fl = 4'b0010;
            nxt = md_last ? MD_DONE : MD_BUSY;
        end else if (st == MD_DONE) begin
            we = 5'b11111;
            mdd = 1'b1;
            nxt = RUN;
        end else if (taken) begin
            we = 5'b11111;
            fl = 4'b1110;
            sel = 1'b1;
            nxt = RUN;
        end else if (bus.ex_md) begin
            we = 5'b00011;
            fl = 4'b0010;
            md_load = 1'b1;
            nxt = MD_BUSY;
        end else if (lu) begin
            we = 5'b00111;
            fl = 4'b0100;
            nxt = RUN;
        end else begin
            we = 5'b11111;
            nxt = RUN;
        end
    end
    assign {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we} = we;
    assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = fl;
    assign bus.pc_sel_branch = sel;
    assign bus.md_done       = mdd;
    assign bus.dmem_req      = memop & ~reset;
    assign bus.state         = st;
    assign bus.stall_cnt     = cnt;
    // state register and saturating count of cycles with the PC held
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= RUN;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (!we[4] && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed vectors against hand-computed control outputs
module tb_pipe_sequencer;
    logic clk = 1'b0;
    logic reset;
    int n_vec = 0;
    int n_bad = 0;
    pipe_sequencer_if #(.CNT_W(16)) bus ();
    pipe_sequencer #(.MD_CYCLES(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [4:0] we;
    logic [3:0] fl;
    assign we = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
    assign fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.ex_MR = 1'b0; bus.ex_WN = 5'd0; bus.ex_md = 1'b0;
        bus.mem_Branch = 1'b0; bus.mem_bne = 1'b0; bus.mem_zero = 1'b0;
        bus.mem_MR = 1'b0; bus.mem_MW = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] wn, input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        bus.ex_MR = 1'b1; bus.ex_WN = wn; bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.mem_MR = 1'b1;
        tick(); tick();
        #1;
        chk("rst_we", 32'(we), 32'h00);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        // normal flow
        tick(); reset = 1'b0; idle(); #1;
        chk("run_we", 32'(we), 32'h1f);
        chk("run_fl", 32'(fl), 32'h0);
        // load-use on rs
        tick(); set_lu(5'd8, 5'd8, 5'd0, 1'b0); #1;
        chk("lu_we", 32'(we), 32'h07);
        chk("lu_fl", 32'(fl), 32'h4);
        chk("lu_cnt_before", 32'(bus.stall_cnt), 32'd0);
        tick(); idle(); #1;
        chk("lu_one_bubble", 32'(we), 32'h1f);
        chk("lu_cnt_after", 32'(bus.stall_cnt), 32'd1);
        // rt match only counts when rt is read
        tick(); set_lu(5'd8, 5'd3, 5'd8, 1'b0); #1;
        chk("lu_rt_unused", 32'(we), 32'h1f);
        tick(); set_lu(5'd8, 5'd3, 5'd8, 1'b1); #1;
        chk("lu_rt_used", 32'(we), 32'h07);
        tick(); set_lu(5'd0, 5'd0, 5'd0, 1'b1); #1;
        chk("lu_reg0", 32'(we), 32'h1f);
        // branches
        tick(); idle(); bus.mem_Branch = 1'b1; bus.mem_bne = 1'b1; bus.mem_zero = 1'b0; #1;
        chk("bne_taken_sel", 32'(bus.pc_sel_branch), 32'h1);
        chk("bne_taken_fl", 32'(fl), 32'he);
        chk("bne_taken_we", 32'(we), 32'h1f);
        bus.mem_zero = 1'b1; #1;
        chk("bne_nt_sel", 32'(bus.pc_sel_branch), 32'h0);
        chk("bne_nt_fl", 32'(fl), 32'h0);
        tick(); bus.mem_bne = 1'b0; bus.mem_zero = 1'b1; #1;
        chk("beq_taken_sel", 32'(bus.pc_sel_branch), 32'h1);
        // branch beats load-use
        tick(); set_lu(5'd9, 5'd9, 5'd0, 1'b0); #1;
        chk("br_lu_we", 32'(we), 32'h1f);
        chk("br_lu_fl", 32'(fl), 32'he);
        chk("br_lu_cnt", 32'(bus.stall_cnt), 32'd2);
        // memory wait: three not-ready cycles then ready
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); bus.mem_MR = 1'b1; bus.dmem_ready = 1'b0; #1;
            chk($sformatf("mw_state%0d", i), 32'(bus.state), i == 0 ? 32'd0 : 32'd1);
            chk($sformatf("mw_we%0d", i), 32'(we), 32'h00);
            chk($sformatf("mw_fl%0d", i), 32'(fl), 32'h1);
            chk($sformatf("mw_req%0d", i), 32'(bus.dmem_req), 32'h1);
        end
        tick(); bus.dmem_ready = 1'b1; #1;
        chk("mw_ready_state", 32'(bus.state), 32'd1);
        chk("mw_ready_we", 32'(we), 32'h1f);
        chk("mw_ready_req", 32'(bus.dmem_req), 32'h1);
        tick(); idle(); #1;
        chk("mw_back_run", 32'(bus.state), 32'd0);
        chk("mw_cnt", 32'(bus.stall_cnt), 32'd5);
        // mult/div, with a load-use pattern present too (md wins)
        tick(); bus.ex_md = 1'b1; set_lu(5'd7, 5'd7, 5'd0, 1'b0); #1;
        chk("md_entry_we", 32'(we), 32'h03);
        chk("md_entry_fl", 32'(fl), 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk($sformatf("md_busy_state%0d", i), 32'(bus.state), 32'd2);
            chk($sformatf("md_busy_we%0d", i), 32'(we), 32'h03);
            chk($sformatf("md_busy_done%0d", i), 32'(bus.md_done), 32'h0);
        end
        tick(); #1;
        chk("md_done_state", 32'(bus.state), 32'd3);
        chk("md_done_pulse", 32'(bus.md_done), 32'h1);
        chk("md_done_we", 32'(we), 32'h1f);
        tick(); idle(); #1;
        chk("md_no_restart", 32'(bus.state), 32'd0);
        chk("md_done_low", 32'(bus.md_done), 32'h0);
        chk("md_cnt", 32'(bus.stall_cnt), 32'd9);
        // reset in the middle of MD_BUSY
        tick(); bus.ex_md = 1'b1; #1;
        tick(); #1;
        chk("mdr_busy1", 32'(bus.state), 32'd2);
        tick(); reset = 1'b1; #1;
        chk("mdr_busy2", 32'(bus.state), 32'd2);
        chk("mdr_rst_we", 32'(we), 32'h00);
        tick(); reset = 1'b0; bus.ex_md = 1'b0; #1;
        chk("mdr_state", 32'(bus.state), 32'd0);
        chk("mdr_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("mdr_we", 32'(we), 32'h1f);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk($sformatf("mdr_no_done%0d", i), 32'(bus.md_done), 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
